// File: rtl/sdram_burst_read.sv
// sdram_burst_read: single-clock SDRAM read engine.
// Issues ACTIVE then READ with auto-precharge, packs DQ beats into words.
module sdram_burst_read #(
    parameter int DQ_W      = 16,
    parameter int PACK      = 2,
    parameter int BURST_LEN = 4,
    parameter int CAS_LAT   = 3,
    parameter int TRCD      = 3,
    parameter int TRP       = 3,
    parameter int BA_W      = 2,
    parameter int ROW_W     = 13,
    parameter int COL_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req,
    input  logic [BA_W-1:0]      rd_ba,
    input  logic [ROW_W-1:0]     rd_row,
    input  logic [COL_W-1:0]     rd_col,
    output logic                 rd_ack,
    output logic                 busy,
    output logic [DQ_W*PACK-1:0] rdata,
    output logic                 rdata_valid,
    output logic                 rd_done,
    output logic [3:0]           sdram_cmd,
    output logic [BA_W-1:0]      sdram_ba,
    output logic [ROW_W-1:0]     sdram_addr,
    input  logic [DQ_W-1:0]      sdram_dq_in
);

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;

    generate
        if ((BURST_LEN % PACK) != 0 || COL_W > 10 ||
            CAS_LAT < 2 || CAS_LAT > 3 ||
            TRCD < 1 || TRP < 0 || ROW_W < 11) begin : g_bad_param
            $error("sdram_burst_read: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_RCD,
        S_RD,
        S_CL,
        S_DATA,
        S_TAIL
    } state_t;

    state_t               state;
    logic [7:0]           cnt;
    logic [3:0]           beat;
    logic [BA_W-1:0]      ba_q;
    logic [COL_W-1:0]     col_q;
    logic [DQ_W*PACK-1:0] pack_q;
    logic [DQ_W*PACK-1:0] word_next;
    logic [3:0]           lane;
    logic                 last_lane;
    logic                 last_beat;
    logic [ROW_W-1:0]     rd_addr;

    // word_next is the word as it stands once the current beat is in place
    always_comb begin
        lane      = beat % 4'(PACK);
        last_lane = (lane == 4'(PACK - 1));
        last_beat = (beat == 4'(BURST_LEN - 1));
        word_next = pack_q;
        word_next[lane*DQ_W +: DQ_W] = sdram_dq_in;
        rd_addr = '0;
        rd_addr[COL_W-1:0] = col_q;
        rd_addr[10] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            beat        <= '0;
            ba_q        <= '0;
            col_q       <= '0;
            pack_q      <= '0;
            rd_ack      <= 1'b0;
            busy        <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rd_done     <= 1'b0;
            sdram_cmd   <= CMD_NOP;
            sdram_ba    <= '0;
            sdram_addr  <= '0;
        end else begin
            rd_ack      <= 1'b0;
            rdata_valid <= 1'b0;
            rd_done     <= 1'b0;
            sdram_cmd   <= CMD_NOP;
            sdram_addr  <= '0;
            case (state)
                S_IDLE: begin
                    if (rd_req) begin
                        state      <= S_ACT;
                        rd_ack     <= 1'b1;
                        busy       <= 1'b1;
                        sdram_cmd  <= CMD_ACT;
                        sdram_ba   <= rd_ba;
                        sdram_addr <= rd_row;
                        ba_q       <= rd_ba;
                        col_q      <= rd_col;
                    end
                end
                S_ACT: begin
                    if (TRCD == 1) begin
                        state      <= S_RD;
                        sdram_cmd  <= CMD_RD;
                        sdram_ba   <= ba_q;
                        sdram_addr <= rd_addr;
                    end else begin
                        state <= S_RCD;
                        cnt   <= 8'(TRCD - 2);
                    end
                end
                S_RCD: begin
                    if (cnt == 8'd0) begin
                        state      <= S_RD;
                        sdram_cmd  <= CMD_RD;
                        sdram_ba   <= ba_q;
                        sdram_addr <= rd_addr;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_RD: begin
                    state <= S_CL;
                    cnt   <= 8'(CAS_LAT - 2);
                end
                S_CL: begin
                    if (cnt == 8'd0) begin
                        state <= S_DATA;
                        beat  <= '0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_DATA: begin
                    pack_q <= word_next;
                    beat   <= beat + 4'd1;
                    if (last_lane) begin
                        rdata       <= word_next;
                        rdata_valid <= 1'b1;
                    end
                    if (last_beat) begin
                        rd_done <= 1'b1;
                        state   <= S_TAIL;
                        cnt     <= 8'(TRP);
                    end
                end
                S_TAIL: begin
                    // busy covers the rd_done cycle plus TRP more
                    if (cnt == 8'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sdram_burst_read.md
Name: sdram_burst_read

Overview:
- Parametrised single-clock SDRAM read engine, successor to the fixed 2-beat read path.
- Accepts one read request per transaction and issues ACTIVE, then READ with auto-precharge.
- Samples the DQ bus in `clk` (no separate capture clock), packs PACK beats per output word and streams BURST_LEN/PACK words with a valid strobe.
- Sits between the controller arbiter (request side) and the SDRAM command/DQ mux (pin side).

Parameters:
- DQ_W, 16, SDRAM data bus width.
- PACK, 2, DQ beats per output word (1, 2 or 4).
- BURST_LEN, 4, DQ beats per READ (1, 2, 4 or 8); must be a multiple of PACK and match the mode register.
- CAS_LAT, 3, CAS latency in clk cycles (2 or 3); must match the mode register.
- TRCD, 3, ACTIVE-to-READ spacing in cycles (≥1).
- TRP, 3, post-burst hold-off in cycles before a new request is accepted (≥0).
- BA_W, 2, bank address width.
- ROW_W, 13, row and SDRAM address width.
- COL_W, 10, column width (≤10).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  read request; level, sampled only in IDLE.
- rd_ba  in  BA_W  bank, captured at accept.
- rd_row  in  ROW_W  row, captured at accept.
- rd_col  in  COL_W  start column, captured at accept.
- rd_ack  out  1  one-cycle pulse: request accepted.
- busy  out  1  high from accept through end of TRP hold-off.
- rdata  out  DQ_W*PACK  packed word; first beat in the LSBs.
- rdata_valid  out  1  one-cycle strobe per packed word.
- rd_done  out  1  one-cycle pulse coincident with the last rdata_valid.
- sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP=0111, ACTIVE=0011, READ=0101.
- sdram_ba  out  BA_W  bank address.
- sdram_addr  out  ROW_W  address bus.
- sdram_dq_in  in  DQ_W  SDRAM DQ input.

Behaviour:
- **Reset:** when rst is high at an edge, all outputs go to the following on the next cycle, regardless of state:
  - sdram_cmd=NOP; sdram_ba=0; sdram_addr=0.
  - rd_ack=0; busy=0; rdata_valid=0; rd_done=0; rdata=0.
  - FSM returns to IDLE; any partially packed word and all remaining burst beats are discarded.
- **Registered outputs:** every output is registered.
- **States:** IDLE → ACT → RCD → RD → CL → DATA → TAIL → IDLE.
- **IDLE:** if rd_req=1 at edge E0, then in cycle 1 (after E0):
  - rd_ack=1, busy=1;
  - sdram_cmd=ACTIVE, sdram_ba=rd_ba, sdram_addr=rd_row;
  - rd_ba/rd_row/rd_col are latched.
- **RCD:** NOP for TRCD-1 cycles.
- **RD:** in cycle T=1+TRCD:
  - sdram_cmd=READ, sdram_ba=latched bank;
  - sdram_addr[COL_W-1:0]=col, sdram_addr[10]=1 (auto-precharge), all other bits 0.
- **Command outside ACT/RD:** sdram_cmd=NOP, sdram_addr=0.
- **CL/DATA beat timing:** beat k (0..BURST_LEN-1) is present on sdram_dq_in in cycle T+CAS_LAT+k and is registered at the end of that cycle.
- **Packing:**
  - Beat k is placed in lane (k mod PACK) of the word being assembled.
  - Word j is presented on rdata with rdata_valid=1 in cycle T+CAS_LAT+(j+1)*PACK.
  - rdata holds its value between strobes.
- **rd_done:** asserted with word BURST_LEN/PACK-1, i.e. cycle T+CAS_LAT+BURST_LEN.
- **TAIL:** busy stays high for TRP further cycles after rd_done, then IDLE. With TRP=0 the FSM is in IDLE the cycle after rd_done.
- **Request handling:**
  - rd_req is ignored outside IDLE; there is no queueing and no rd_ack for an ignored request.
  - rd_req held high is re-accepted at the first IDLE edge.
- **Column wrap:** column wrap within the burst is done by the device (sequential); the block transfers exactly BURST_LEN beats.
- **Degenerate case PACK=BURST_LEN:** single strobe, which is also rd_done.
- **Elaboration checks:** BURST_LEN % PACK != 0, COL_W>10 or CAS_LAT outside 2..3 is an elaboration error (generate-time check).

Test Plan:
- **Default params, single read:** rd_req pulse at E0, ba=2, row=0x0ABC, col=0x004, beats D0..D3=0x1111,0x2222,0x3333,0x4444 in cycles 7..10 →
  - cycle 1: rd_ack=1, ACTIVE, ba=2, addr=0x0ABC;
  - cycle 4: READ, addr=0x0404;
  - rdata_valid in cycle 9 with rdata=0x22221111 and in cycle 11 with rdata=0x44443333;
  - rd_done in cycle 11; busy=1 for cycles 1..14.
- **Back-to-back:** rd_req held high → second rd_ack in cycle 16, second ACTIVE in cycle 16; rd_req in cycles 2..14 produces no ack.
- **Reset mid-burst:** rst=1 at the edge ending cycle 8 → cycle 9 shows rdata_valid=0, busy=0, cmd=NOP; no rd_done; the next request behaves as in the first scenario.
- **PACK=1, BURST_LEN=8, CAS_LAT=2, TRCD=2:** READ in cycle 3; 8 strobes in cycles 6..13 with rdata equal to the beat from the previous cycle; rd_done in cycle 13.
- **PACK=4, BURST_LEN=4, TRP=0:** single strobe in cycle T+CAS_LAT+4 = 11 with rdata={D3,D2,D1,D0} and rd_done=1 in the same cycle; new rd_req accepted at the edge ending cycle 12, so rd_ack=1 in cycle 13.
